// File: rtl/adc_serial_if_pkg.sv
// Shared constants for the serial ADC responder: one-hot FSM encoding and default frame geometry.
package adc_serial_if_pkg;

    localparam int unsigned LEAD_BITS_DEF = 4;
    localparam int unsigned DATA_W_DEF    = 12;
    localparam int unsigned STATE_W       = 5;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 5'b00001,
        ST_CS_SETUP = 5'b00010,
        ST_SHIFT    = 5'b00100,
        ST_DONE     = 5'b01000,
        ST_QUIET    = 5'b10000
    } state_t;

endpackage

// File: rtl/adc_sclk_gen.sv
// SCLK generator: after start, emits NBITS periods of CLK_DIV cycles low then CLK_DIV cycles high.
module adc_sclk_gen #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned NBITS   = 16
) (
    input  logic clk_i,
    input  logic reset_n,
    input  logic start,
    output logic sclk,
    output logic busy,
    output logic rise_c,
    output logic done_c
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned BIT_W = $clog2(NBITS);

    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic             half_end_c;

    assign half_end_c = busy && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign rise_c     = half_end_c && !sclk;
    assign done_c     = rise_c && (bit_cnt == BIT_W'(NBITS - 1));

    // sclk idles high; the bit counter advances on each falling edge after the first
    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            sclk    <= 1'b1;
            busy    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (start) begin
            sclk    <= 1'b0;
            busy    <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (busy) begin
            if (half_end_c) begin
                div_cnt <= '0;
                sclk    <= !sclk;
                if (sclk) begin
                    bit_cnt <= bit_cnt + BIT_W'(1);
                end
                if (done_c) begin
                    busy <= 1'b0;
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/adc_serial_if.sv
// ADC-side responder: a request edge triggers one serial ADC conversion, then rdy rises with the sample.
// Optional ADC_SERIAL_IF_TEST_PATTERN_EN returns an incrementing counter instead of ADC data.
module adc_serial_if
    import adc_serial_if_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned LEAD_BITS    = LEAD_BITS_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned QUIET_CYCLES = 8
) (
    input  logic              clk_i,
    input  logic              reset_n,
    input  logic              adc_data_req_i,
    output logic              adc_data_rdy_o,
    output logic [DATA_W-1:0] adc_data_o,
    output logic              lead_err_o,
    output logic              adc_cs_n_o,
    output logic              adc_sclk_o,
    input  logic              adc_sdata_i
);

    localparam int unsigned NBITS   = LEAD_BITS + DATA_W;
    localparam int unsigned CNT_MAX = (CLK_DIV > QUIET_CYCLES) ? CLK_DIV : QUIET_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    logic             req_s1, req_s2, req_s3, req_re;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pending;
    logic [NBITS-1:0] shift_q;
    logic             gen_start_c, gen_busy, gen_rise_c, gen_done_c;
`ifdef ADC_SERIAL_IF_TEST_PATTERN_EN
    logic [DATA_W-1:0] pat_cnt;
`endif

    // While in reset s2/s3 track together so a level already high at release is not an edge
    always_ff @(posedge clk_i) begin
        req_s1 <= adc_data_req_i;
        req_s2 <= req_s1;
        if (!reset_n) begin
            req_s3 <= req_s1;
            req_re <= 1'b0;
        end else begin
            req_s3 <= req_s2;
            req_re <= req_s2 & ~req_s3;
        end
    end

    assign gen_start_c = (state == ST_CS_SETUP) && (cnt == CNT_W'(CLK_DIV - 1)) && !gen_busy;

    adc_sclk_gen #(
        .CLK_DIV (CLK_DIV),
        .NBITS   (NBITS)
    ) u_sclk_gen (
        .clk_i   (clk_i),
        .reset_n (reset_n),
        .start   (gen_start_c),
        .sclk    (adc_sclk_o),
        .busy    (gen_busy),
        .rise_c  (gen_rise_c),
        .done_c  (gen_done_c)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            pending        <= 1'b0;
            shift_q        <= '0;
            adc_data_rdy_o <= 1'b1;
            adc_data_o     <= '0;
            lead_err_o     <= 1'b0;
            adc_cs_n_o     <= 1'b1;
`ifdef ADC_SERIAL_IF_TEST_PATTERN_EN
            pat_cnt        <= '0;
`endif
        end else begin
            if (req_re && (state != ST_IDLE)) begin
                pending <= 1'b1;
            end
            if (gen_rise_c) begin
                shift_q <= {shift_q[NBITS-2:0], adc_sdata_i};
            end
            case (state)
                ST_IDLE: begin
                    if (req_re || pending) begin
                        state          <= ST_CS_SETUP;
                        cnt            <= '0;
                        adc_cs_n_o     <= 1'b0;
                        adc_data_rdy_o <= 1'b0;
                        pending        <= 1'b0;
                    end
                end
                ST_CS_SETUP: begin
                    if (gen_start_c) begin
                        state <= ST_SHIFT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (gen_done_c) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
`ifdef ADC_SERIAL_IF_TEST_PATTERN_EN
                    adc_data_o <= pat_cnt;
                    lead_err_o <= 1'b0;
                    pat_cnt    <= pat_cnt + DATA_W'(1);
`else
                    adc_data_o <= shift_q[DATA_W-1:0];
                    lead_err_o <= |shift_q[NBITS-1:DATA_W];
`endif
                    adc_data_rdy_o <= 1'b1;
                    adc_cs_n_o     <= 1'b1;
                    cnt            <= '0;
                    state          <= ST_QUIET;
                end
                ST_QUIET: begin
                    if (cnt == CNT_W'(QUIET_CYCLES - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_serial_if.sv
// Bench for adc_serial_if: ADC pin model, timeline reference model, per-cycle compare and directed/random requests.
module tb_adc_serial_if;

    localparam int CD   = 4;
    localparam int LB   = 4;
    localparam int DW   = 12;
    localparam int QC   = 8;
    localparam int NB   = LB + DW;
    localparam int SH   = 2 * NB * CD;
    localparam int T    = 1 + SH + QC;
    localparam int NONE = -1000000;

    logic          clk_i = 1'b0;
    logic          reset_n = 1'b0;
    logic          req = 1'b0;
    logic          sdata = 1'b0;
    logic          rdy, lead, cs_n, sclk;
    logic [DW-1:0] data;

    always #5 clk_i = ~clk_i;

    adc_serial_if dut (
        .clk_i          (clk_i),
        .reset_n        (reset_n),
        .adc_data_req_i (req),
        .adc_data_rdy_o (rdy),
        .adc_data_o     (data),
        .lead_err_o     (lead),
        .adc_cs_n_o     (cs_n),
        .adc_sclk_o     (sclk),
        .adc_sdata_i    (sdata)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // ADC pin model: loads a 16-bit frame at CS_n fall, presents the next bit on each SCLK fall
    logic [NB-1:0] adc_q[$];
    logic [NB-1:0] a_word = '0;
    int            a_idx = 0;
    always @(negedge cs_n) begin
        a_word = (adc_q.size() > 0) ? adc_q.pop_front() : '0;
        a_idx  = 0;
    end
    always @(negedge sclk) begin
        if (!cs_n && a_idx < NB) begin
            sdata = a_word[NB-1-a_idx];
            a_idx++;
        end
    end

    // Reference model: conversion timeline relative to its start cycle S (cs_n fall)
    logic [NB-1:0] exp_q[$];
    int            m_evals[$];
    int            m_s = NONE;
    bit            m_pend = 0;
    bit            m_prev_req = 0;
    bit            m_started = 0;
    logic [NB-1:0] m_word = '0;
    logic [DW-1:0] m_data = '0;
    logic [DW-1:0] m_pat = '0;
    bit            m_lead = 0;
    bit            e_rdy = 1, e_cs = 1, e_sclk = 1;
    int            k;

    task m_start();
        m_s    = cyc;
        m_pend = 0;
        m_word = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        m_started = 1;
    endtask

    always @(posedge clk_i) begin
        cyc = cyc + 1;
        if (!reset_n) begin
            m_s    = NONE;
            m_pend = 0;
            m_evals.delete();
            m_data = '0;
            m_lead = 0;
            m_pat  = '0;
            m_prev_req = req;
        end else begin
            m_started = 0;
            if (req && !m_prev_req) m_evals.push_back(cyc + 3);
            m_prev_req = req;
            if (m_pend && m_s != NONE && cyc == m_s + T + 1) m_start();
            if (m_evals.size() > 0 && m_evals[0] == cyc) begin
                void'(m_evals.pop_front());
                if (!m_started) begin
                    if (m_s == NONE || cyc > m_s + T) m_start();
                    else m_pend = 1;
                end
            end
            if (m_s != NONE && cyc == m_s + SH + 1) begin
`ifdef ADC_SERIAL_IF_TEST_PATTERN_EN
                m_data = m_pat;
                m_pat  = m_pat + 1'b1;
                m_lead = 0;
`else
                m_data = m_word[DW-1:0];
                m_lead = |m_word[NB-1:DW];
`endif
            end
        end
        if (m_s == NONE) begin
            e_rdy = 1; e_cs = 1; e_sclk = 1;
        end else begin
            k      = cyc - m_s;
            e_cs   = !(k < SH + 1);
            e_rdy  = e_cs;
            e_sclk = (k >= CD && k < CD + SH) ? (((k - CD) / CD) % 2 == 1) : 1'b1;
        end
    end

    // Per-cycle compare plus event monitor for the directed timing checks
    bit p_rdy, p_cs, p_sclk, mon_ok = 0;
    int rdy_fall_cyc = 0, rdy_rise_cyc = 0, cs_fall_cyc = 0, cs_rise_cyc = 0;
    int rdy_rises = 0, cs_falls = 0, sclk_falls = 0, sclk_edges = 0;
    always @(negedge clk_i) begin
        if (chk_en) begin
            check("rdy",      32'(rdy),  32'(e_rdy));
            check("cs_n",     32'(cs_n), 32'(e_cs));
            check("sclk",     32'(sclk), 32'(e_sclk));
            check("data",     32'(data), 32'(m_data));
            check("lead_err", 32'(lead), 32'(m_lead));
            if (mon_ok) begin
                if (p_rdy && !rdy) rdy_fall_cyc = cyc;
                if (!p_rdy && rdy) begin rdy_rise_cyc = cyc; rdy_rises++; end
                if (p_cs && !cs_n) begin cs_fall_cyc = cyc; cs_falls++; sclk_falls = 0; end
                if (!p_cs && cs_n) cs_rise_cyc = cyc;
                if (p_sclk && !sclk) sclk_falls++;
                if (p_sclk != sclk) sclk_edges++;
            end
            p_rdy = rdy; p_cs = cs_n; p_sclk = sclk; mon_ok = 1;
        end
    end

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic pulse(input int hi, output int r);
        req = 1'b1;
        r = cyc + 1;
        repeat (hi) tick();
        req = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target - 1) tick();
    endtask

    task automatic wait_rises(input int n0, input int n, input int budget);
        int i = 0;
        while (rdy_rises < n0 + n && i < budget) begin tick(); i++; end
        check("rdy_rise_timeout", 32'(rdy_rises - n0), 32'(n));
    endtask

    task automatic convert(input logic [NB-1:0] w, output int r);
        int n0 = rdy_rises;
        adc_q.push_back(w);
        exp_q.push_back(w);
        pulse(3, r);
        wait_rises(n0, 1, 400);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        chk_en = 1;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r, r0, n0, e0, f0, first_rise;
        do_reset();
        check("reset_rdy", 32'(rdy), 32'd1);
        check("reset_data", 32'(data), 32'd0);
        check("reset_cs_n", 32'(cs_n), 32'd1);
        check("reset_sclk", 32'(sclk), 32'd1);
        repeat (200) tick();
        check("idle_sclk_edges", 32'(sclk_edges), 32'd0);

        // single conversion
        convert(16'h0ABC, r);
        check("single_rdy_fall", 32'(rdy_fall_cyc - r), 32'd3);
        check("single_cs_fall", 32'(cs_fall_cyc - r), 32'd3);
        check("single_rdy_rise", 32'(rdy_rise_cyc - r), 32'd132);
        check("single_cs_rise", 32'(cs_rise_cyc - r), 32'd132);
        check("single_sclk_falls", 32'(sclk_falls), 32'd16);
`ifndef ADC_SERIAL_IF_TEST_PATTERN_EN
        check("single_data", 32'(data), 32'h0ABC);
        check("single_lead", 32'(lead), 32'd0);
`endif
        repeat (20) tick();

        // leading-bit error then clear
        convert(16'h8ABC, r);
`ifndef ADC_SERIAL_IF_TEST_PATTERN_EN
        check("lead_data", 32'(data), 32'h0ABC);
        check("lead_set", 32'(lead), 32'd1);
`endif
        repeat (20) tick();
        convert(16'h0123, r);
`ifndef ADC_SERIAL_IF_TEST_PATTERN_EN
        check("lead_clr_data", 32'(data), 32'h0123);
        check("lead_clr", 32'(lead), 32'd0);
`endif
        repeat (20) tick();

        // requests while busy: one extra conversion only
        n0 = rdy_rises;
        f0 = cs_falls;
        adc_q.push_back(16'h0555); exp_q.push_back(16'h0555);
        adc_q.push_back(16'h0AAA); exp_q.push_back(16'h0AAA);
        pulse(2, r0);
        wait_until(r0 + 20); pulse(2, r);
        wait_until(r0 + 40); pulse(2, r);
        wait_until(r0 + 60); pulse(2, r);
        wait_rises(n0, 1, 400);
        first_rise = rdy_rise_cyc;
        wait_rises(n0, 2, 400);
        check("pending_gap", 32'(cs_fall_cyc - first_rise), 32'd9);
        repeat (200) tick();
        check("pending_count", 32'(cs_falls - f0), 32'd2);
        convert(16'h0F0F, r);
        check("after_pending_rise", 32'(rdy_rise_cyc - r), 32'd132);
        repeat (20) tick();

        // random requests, including while busy and during quiet time
        for (int i = 0; i < 12; i++) begin
            logic [NB-1:0] w;
            w = NB'($urandom);
            adc_q.push_back(w);
            exp_q.push_back(w);
            pulse(1 + int'($urandom_range(3)), r);
            repeat (1 + int'($urandom_range(200))) tick();
        end
        repeat (400) tick();
        adc_q.delete();
        exp_q.delete();

        // reset mid-shift
        adc_q.push_back(16'h0777); exp_q.push_back(16'h0777);
        pulse(2, r);
        wait_until(r + 60);
        reset_n = 1'b0;
        tick();
        check("midrst_cs_n", 32'(cs_n), 32'd1);
        check("midrst_sclk", 32'(sclk), 32'd1);
        check("midrst_rdy", 32'(rdy), 32'd1);
        check("midrst_data", 32'(data), 32'd0);
        e0 = sclk_edges;
        tick();
        reset_n = 1'b1;
        repeat (80) tick();
        check("midrst_no_sclk", 32'(sclk_edges - e0), 32'd0);
        convert(16'h0321, r);
        check("recover_rise", 32'(rdy_rise_cyc - r), 32'd132);
`ifndef ADC_SERIAL_IF_TEST_PATTERN_EN
        check("recover_data", 32'(data), 32'h0321);
`endif
        repeat (20) tick();

`ifdef ADC_SERIAL_IF_TEST_PATTERN_EN
        // requester model: 8 handshakes after reset return 0..7
        do_reset();
        repeat (5) tick();
        for (int i = 0; i < 8; i++) begin
            n0 = rdy_rises;
            req = 1'b1;
            r = cyc + 1;
            wait_rises(n0, 1, 400);
            req = 1'b0;
            check("pattern_data", 32'(data), 32'(i));
            check("pattern_rise", 32'(rdy_rise_cyc - r), 32'd132);
            repeat (12) tick();
        end
`endif

        repeat (20) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
